// File: rtl/cla_flow_alloc_age.sv
// Flow-entry allocator and aging engine: pops the flow free list for new flows,
// tracks per-entry last-hit timestamps and releases entries on delete or idle timeout.
module cla_flow_alloc_age #(
    parameter int BPTR_NBITS = 4,
    parameter int TS_NBITS   = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  alloc_req,
    output logic                  alloc_ack,
    output logic                  alloc_fail,
    output logic [BPTR_NBITS-1:0] alloc_ptr,
    input  logic                  freeb_init_done,
    input  logic                  freeb_empty,
    input  logic [BPTR_NBITS-1:0] free_buf_ptr,
    output logic                  free_buf_rd,
    input  logic                  hit_valid,
    input  logic [BPTR_NBITS-1:0] hit_ptr,
    input  logic                  del_valid,
    input  logic [BPTR_NBITS-1:0] del_ptr,
    input  logic                  tick,
    input  logic                  age_en,
    input  logic [TS_NBITS-1:0]   age_timeout,
    output logic                  rel_buf_valid,
    output logic [BPTR_NBITS-1:0] rel_buf_ptr,
    output logic [15:0]           aged_cnt
);

    localparam int DEPTH = 1 << BPTR_NBITS;

    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      valid_d;
    logic [TS_NBITS-1:0]   ts_mem [DEPTH];
    logic [TS_NBITS-1:0]   now_q;
    logic [BPTR_NBITS-1:0] scan_idx_q;

    logic                  pop_p0;
    logic                  fail_p0;
    logic                  hit_ok_p0;
    logic                  del_ok_p0;
    logic                  scan_run_p0;
    logic                  scan_fresh_p0;
    logic                  expire_p0;
    logic [TS_NBITS-1:0]   scan_age_p0;
    logic                  rel_vld_p0;
    logic [BPTR_NBITS-1:0] rel_ptr_p0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Decision stage: everything below is evaluated on pre-cycle state.
    // Flush drops every request presented in its cycle.
    assign pop_p0      = alloc_req & freeb_init_done & ~freeb_empty & ~flush;
    assign fail_p0     = alloc_req & ~flush & ~(freeb_init_done & ~freeb_empty);
    assign free_buf_rd = pop_p0;
    assign hit_ok_p0   = hit_valid & ~flush & valid_q[hit_ptr];
    assign del_ok_p0   = del_valid & ~flush & valid_q[del_ptr];

    // Any presented delete owns the release port, so the scanner waits it out.
    assign scan_run_p0   = age_en & (age_timeout != '0) & ~del_valid & ~flush;
    assign scan_age_p0   = now_q - ts_mem[scan_idx_q];
    assign scan_fresh_p0 = (hit_ok_p0 & (hit_ptr == scan_idx_q)) |
                           (pop_p0 & (free_buf_ptr == scan_idx_q));
    assign expire_p0     = scan_run_p0 & valid_q[scan_idx_q] & ~scan_fresh_p0 &
                           (scan_age_p0 >= age_timeout);

    assign rel_vld_p0 = del_ok_p0 | expire_p0;
    assign rel_ptr_p0 = del_ok_p0 ? del_ptr : scan_idx_q;

    // Allocation set is applied last so it wins over a same-pointer delete.
    always_comb begin
        valid_d = valid_q;
        if (del_ok_p0) begin
            valid_d[del_ptr] = 1'b0;
        end
        if (expire_p0) begin
            valid_d[scan_idx_q] = 1'b0;
        end
        if (pop_p0) begin
            valid_d[free_buf_ptr] = 1'b1;
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    // Register stage: responses and releases appear one cycle after the decision.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q       <= '0;
            now_q         <= '0;
            scan_idx_q    <= '0;
            alloc_ack     <= 1'b0;
            alloc_fail    <= 1'b0;
            alloc_ptr     <= '0;
            rel_buf_valid <= 1'b0;
            rel_buf_ptr   <= '0;
            aged_cnt      <= '0;
        end else begin
            valid_q    <= valid_d;
            alloc_ack  <= pop_p0;
            alloc_fail <= fail_p0;
            if (pop_p0) begin
                alloc_ptr <= free_buf_ptr;
            end
            rel_buf_valid <= rel_vld_p0;
            if (rel_vld_p0) begin
                rel_buf_ptr <= rel_ptr_p0;
            end
            if (tick) begin
                now_q <= now_q + 1'b1;
            end
            if (flush) begin
                scan_idx_q <= '0;
            end else if (scan_run_p0) begin
                scan_idx_q <= scan_idx_q + 1'b1;
            end
            if (flush) begin
                aged_cnt <= '0;
            end else if (expire_p0) begin
                aged_cnt <= sat_inc16(aged_cnt);
            end
        end
    end

    // Timestamps carry no reset; an entry's stamp is always written before its valid bit is read.
    always_ff @(posedge clk) begin
        if (pop_p0) begin
            ts_mem[free_buf_ptr] <= now_q;
        end
        if (hit_ok_p0) begin
            ts_mem[hit_ptr] <= now_q;
        end
    end

endmodule
